// File: rtl/vga_timing_gen.sv
// Raster scan timing generator: drives framebuffer reads; outputs appear 2 cycles after the counter position.
// No backpressure: rd_data is taken the cycle after rd_en and the scan never stalls.
module vga_timing_gen #(
   parameter int H_ACTIVE = 400,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 48,
   parameter int H_BP     = 64,
   parameter int V_ACTIVE = 300,
   parameter int V_FP     = 3,
   parameter int V_SYNC   = 4,
   parameter int V_BP     = 13
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        en,
   input  logic [16:0] fb_base,
   output logic        rd_en,
   output logic [16:0] rd_addr,
   input  logic [11:0] rd_data,
   output logic        dat_hsync,
   output logic        dat_vsync,
   output logic [3:0]  dat_vga_r,
   output logic [3:0]  dat_vga_g,
   output logic [3:0]  dat_vga_b,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

   typedef enum logic [1:0] {ST_RST, ST_IDLE, ST_SCAN} state_t;

   state_t          state, state_nxt;
   logic            scan;
   logic [HW-1:0]   h_cnt;
   logic [VW-1:0]   v_cnt;
   logic [16:0]     addr_q;
   logic            active, h_wrap, v_wrap, h_sync_on, v_sync_on, at_origin;
   logic            s1_vld, s1_hs, s1_vs, s1_fs;

   // The cycle after reset never scans, so that the first frame sees a fresh fb_base in addr_q.
   always_ff @(posedge clock) begin
      if (reset) state <= ST_RST;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      scan      = 1'b0;
      case (state)
         ST_RST:  state_nxt = ST_IDLE;
         ST_IDLE: begin
            scan = en;
            if (en) state_nxt = ST_SCAN;
         end
         ST_SCAN: begin
            scan = en;
            if (!en) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_RST;
      endcase
   end

   assign active    = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
   assign h_wrap    = (h_cnt == H_LAST);
   assign v_wrap    = (v_cnt == V_LAST);
   assign h_sync_on = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
   assign v_sync_on = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
   assign at_origin = (h_cnt == '0) && (v_cnt == '0);

   assign rd_en   = scan && active;
   assign rd_addr = addr_q;

   // While not scanning, addr_q tracks fb_base so a restart begins at the latest base.
   always_ff @(posedge clock) begin
      if (reset) begin
         h_cnt  <= '0;
         v_cnt  <= '0;
         addr_q <= '0;
      end else if (!scan) begin
         h_cnt  <= '0;
         v_cnt  <= '0;
         addr_q <= fb_base;
      end else begin
         h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
         if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
         if (h_wrap && v_wrap) addr_q <= fb_base;
         else if (active)      addr_q <= addr_q + 17'd1;
      end
   end

   // Two-stage delay keeps sync/blanking aligned with rd_data; both stages flush when scanning stops.
   always_ff @(posedge clock) begin
      if (reset || !scan) begin
         s1_vld      <= 1'b0;
         s1_hs       <= 1'b1;
         s1_vs       <= 1'b1;
         s1_fs       <= 1'b0;
         dat_hsync   <= 1'b1;
         dat_vsync   <= 1'b1;
         dat_vga_r   <= 4'd0;
         dat_vga_g   <= 4'd0;
         dat_vga_b   <= 4'd0;
         frame_start <= 1'b0;
      end else begin
         s1_vld      <= active;
         s1_hs       <= !h_sync_on;
         s1_vs       <= !v_sync_on;
         s1_fs       <= at_origin;
         dat_hsync   <= s1_hs;
         dat_vsync   <= s1_vs;
         dat_vga_r   <= s1_vld ? rd_data[11:8] : 4'd0;
         dat_vga_g   <= s1_vld ? rd_data[7:4]  : 4'd0;
         dat_vga_b   <= s1_vld ? rd_data[3:0]  : 4'd0;
         frame_start <= s1_fs;
      end
   end

endmodule
